// File: rtl/bp_trace_scoreboard_pkg.sv
// +----------------------------------------------------------------------------+
// | bp_trace_pkg                                                               |
// | Shared types for the branch-trace scoreboard: branch kinds, error causes,  |
// | queued prediction record.                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bp_trace_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_RES_EMPTY    = 3'd1,
    ERR_RES_PTR      = 3'd2,
    ERR_RES_PC       = 3'd3,
    ERR_PRED_PTR     = 3'd4,
    ERR_PRED_NOREADY = 3'd5
  } err_e;

  typedef struct packed {
    logic [31:0] ptr;
    logic [31:0] pc;
    logic [31:0] target;
    br_type_e    br_type;
    logic        taken;
  } bp_entry_t;

  localparam logic [31:0] NPC_INC = 32'd4;

endpackage

`default_nettype wire

// File: rtl/bp_trace_scoreboard_if.sv
// +----------------------------------------------------------------------------+
// | bp_trace_scoreboard_if                                                     |
// | Prediction, resolve, flush, redirect and status bundle of the scoreboard.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bp_trace_scoreboard_if import bp_trace_pkg::*; #(
  parameter int CNT_W = 32
) ();

  logic             pred_valid;
  logic             pred_ready;
  logic [31:0]      pred_ptr;
  logic [31:0]      pred_pc;
  logic [31:0]      pred_target;
  br_type_e         pred_br_type;
  logic             pred_taken;

  logic             res_valid;
  logic [31:0]      res_ptr;
  logic [31:0]      res_pc;
  logic [31:0]      res_target;
  br_type_e         res_br_type;
  logic             res_taken;

  logic             flush_valid;
  logic [31:0]      flush_ptr;

  logic             redir_valid;
  logic [31:0]      redir_pc;
  logic [31:0]      redir_ptr;

  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_dir_miss;
  logic [CNT_W-1:0] cnt_tgt_miss;
  logic             err;
  err_e             err_code;

  modport master (
    output pred_valid, pred_ptr, pred_pc, pred_target, pred_br_type, pred_taken,
    output res_valid, res_ptr, res_pc, res_target, res_br_type, res_taken,
    output flush_valid, flush_ptr,
    input  pred_ready, redir_valid, redir_pc, redir_ptr,
    input  cnt_branch, cnt_dir_miss, cnt_tgt_miss, err, err_code
  );

  modport slave (
    input  pred_valid, pred_ptr, pred_pc, pred_target, pred_br_type, pred_taken,
    input  res_valid, res_ptr, res_pc, res_target, res_br_type, res_taken,
    input  flush_valid, flush_ptr,
    output pred_ready, redir_valid, redir_pc, redir_ptr,
    output cnt_branch, cnt_dir_miss, cnt_tgt_miss, err, err_code
  );

endinterface

`default_nettype wire

// File: rtl/bp_trace_scoreboard_queue.sv
// +----------------------------------------------------------------------------+
// | bp_trace_queue                                                             |
// | DEPTH-entry circular FIFO of in-flight predictions with wrap-bit pointers. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_trace_queue import bp_trace_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  bp_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output bp_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  bp_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en;

  assign wr_en = push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot index but opposite wrap bit means the writer has lapped the reader.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/bp_trace_scoreboard.sv
// +----------------------------------------------------------------------------+
// | bp_trace_scoreboard                                                        |
// | Matches resolved branches to queued predictions, raises redirects, keeps   |
// | miss statistics and a sticky protocol error.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_trace_scoreboard import bp_trace_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  bp_trace_scoreboard_if.slave bus
);

  localparam logic [0:0]       ST_RUN  = 1'b0;
  localparam logic [0:0]       ST_ERR  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [31:0]      exp_ptr_q, exp_ptr_d;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [31:0]      redir_ptr_q, redir_ptr_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_dir_q, cnt_dir_d;
  logic [CNT_W-1:0] cnt_tgt_q, cnt_tgt_d;
  logic             err_q, err_d;
  err_e             err_code_q, err_code_d;

  bp_entry_t head, push_entry;
  logic      q_full, q_empty, q_push, q_pop;
  logic      run, pred_fire, res_act, dir_miss, tgt_miss;
  err_e      err_now;

  assign run            = (state_q == ST_RUN);
  assign bus.pred_ready = run & ~q_full;
  assign pred_fire      = bus.pred_valid & bus.pred_ready & ~bus.flush_valid;
  assign res_act        = bus.res_valid & run & ~bus.flush_valid;

  // A wrong branch type is charged as a direction miss, never as a target miss.
  assign dir_miss = (bus.res_taken != head.taken) || (bus.res_br_type != head.br_type);
  assign tgt_miss = !dir_miss && bus.res_taken && (bus.res_target != head.target);

  always_comb begin
    err_now = ERR_NONE;
    if (res_act && q_empty)                          err_now = ERR_RES_EMPTY;
    else if (res_act && bus.res_ptr != head.ptr)     err_now = ERR_RES_PTR;
    else if (res_act && bus.res_pc != head.pc)       err_now = ERR_RES_PC;
    else if (pred_fire && bus.pred_ptr != exp_ptr_q) err_now = ERR_PRED_PTR;
    else if (bus.pred_valid && !bus.pred_ready && !q_full && !bus.flush_valid)
                                                     err_now = ERR_PRED_NOREADY;
  end

  assign push_entry = '{ptr: bus.pred_ptr, pc: bus.pred_pc, target: bus.pred_target,
                        br_type: bus.pred_br_type, taken: bus.pred_taken};
  assign q_push = pred_fire && (err_now == ERR_NONE);
  assign q_pop  = res_act && (err_now == ERR_NONE);

  bp_trace_queue #(.DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .flush     (bus.flush_valid),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_d       = state_q;
    exp_ptr_d     = exp_ptr_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    redir_ptr_d   = redir_ptr_q;
    cnt_branch_d  = cnt_branch_q;
    cnt_dir_d     = cnt_dir_q;
    cnt_tgt_d     = cnt_tgt_q;
    err_d         = err_q;
    err_code_d    = err_code_q;

    if (bus.flush_valid) exp_ptr_d = bus.flush_ptr;
    else if (q_push)     exp_ptr_d = exp_ptr_q + 32'd1;

    if (run && err_now != ERR_NONE) begin
      state_d    = ST_ERR;
      err_d      = 1'b1;
      err_code_d = err_now;
    end else if (q_pop) begin
      cnt_branch_d = cnt_branch_q + CNT_ONE;
      if (dir_miss) cnt_dir_d = cnt_dir_q + CNT_ONE;
      if (tgt_miss) cnt_tgt_d = cnt_tgt_q + CNT_ONE;
      if (dir_miss || tgt_miss) begin
        redir_valid_d = 1'b1;
        redir_pc_d    = bus.res_taken ? bus.res_target : bus.res_pc + NPC_INC;
        redir_ptr_d   = bus.res_ptr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      exp_ptr_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      redir_ptr_q   <= '0;
      cnt_branch_q  <= '0;
      cnt_dir_q     <= '0;
      cnt_tgt_q     <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      exp_ptr_q     <= exp_ptr_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      redir_ptr_q   <= redir_ptr_d;
      cnt_branch_q  <= cnt_branch_d;
      cnt_dir_q     <= cnt_dir_d;
      cnt_tgt_q     <= cnt_tgt_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign bus.redir_valid  = redir_valid_q;
  assign bus.redir_pc     = redir_pc_q;
  assign bus.redir_ptr    = redir_ptr_q;
  assign bus.cnt_branch   = cnt_branch_q;
  assign bus.cnt_dir_miss = cnt_dir_q;
  assign bus.cnt_tgt_miss = cnt_tgt_q;
  assign bus.err          = err_q;
  assign bus.err_code     = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_trace_scoreboard.sv
// +----------------------------------------------------------------------------+
// | tb_bp_trace_scoreboard                                                     |
// | Directed self-checking bench for bp_trace_scoreboard.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bp_trace_scoreboard;
  import bp_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bp_trace_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  bp_trace_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pred_valid   = 1'b0;
    bus.pred_ptr     = '0;
    bus.pred_pc      = '0;
    bus.pred_target  = '0;
    bus.pred_br_type = BR_COND;
    bus.pred_taken   = 1'b0;
    bus.res_valid    = 1'b0;
    bus.res_ptr      = '0;
    bus.res_pc       = '0;
    bus.res_target   = '0;
    bus.res_br_type  = BR_COND;
    bus.res_taken    = 1'b0;
    bus.flush_valid  = 1'b0;
    bus.flush_ptr    = '0;
  endtask

  task automatic set_pred(input logic [31:0] ptr, input logic [31:0] pc,
                          input logic [31:0] tgt, input br_type_e t, input logic tk);
    bus.pred_valid   = 1'b1;
    bus.pred_ptr     = ptr;
    bus.pred_pc      = pc;
    bus.pred_target  = tgt;
    bus.pred_br_type = t;
    bus.pred_taken   = tk;
  endtask

  task automatic set_res(input logic [31:0] ptr, input logic [31:0] pc,
                         input logic [31:0] tgt, input br_type_e t, input logic tk);
    bus.res_valid   = 1'b1;
    bus.res_ptr     = ptr;
    bus.res_pc      = pc;
    bus.res_target  = tgt;
    bus.res_br_type = t;
    bus.res_taken   = tk;
  endtask

  task automatic push(input logic [31:0] ptr, input logic [31:0] pc,
                      input logic [31:0] tgt, input br_type_e t, input logic tk);
    set_pred(ptr, pc, tgt, t, tk);
    tick();
    bus.pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] ptr, input logic [31:0] pc,
                         input logic [31:0] tgt, input br_type_e t, input logic tk);
    set_res(ptr, pc, tgt, t, tk);
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_pred_ready", bus.pred_ready, 1);
    check("rst_err", bus.err, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_cnt_branch", bus.cnt_branch, 0);
    check("rst_redir_valid", bus.redir_valid, 0);

    // Correct stream ptr 0..3
    for (int i = 0; i < 4; i++)
      push(32'(i), 32'(32'h1000 + 16 * i), 32'(32'h2000 + i), BR_COND, 1'b1);
    for (int i = 0; i < 4; i++) begin
      resolve(32'(i), 32'(32'h1000 + 16 * i), 32'(32'h2000 + i), BR_COND, 1'b1);
      check("stream_no_redir", bus.redir_valid, 0);
    end
    check("stream_cnt_branch", bus.cnt_branch, 4);
    check("stream_cnt_dir", bus.cnt_dir_miss, 0);
    check("stream_cnt_tgt", bus.cnt_tgt_miss, 0);
    check("stream_err", bus.err, 0);

    // Reset mid-run with three entries queued
    push(32'd4, 32'h1040, 32'h0, BR_COND, 1'b0);
    push(32'd5, 32'h1050, 32'h0, BR_COND, 1'b0);
    push(32'd6, 32'h1060, 32'h0, BR_COND, 1'b0);
    pulse_reset();
    check("midrst_pred_ready", bus.pred_ready, 1);
    check("midrst_cnt_branch", bus.cnt_branch, 0);
    check("midrst_err", bus.err, 0);

    // Direction miss: not-taken predicted, taken resolved
    push(32'd0, 32'h8000_0000, 32'h8000_0040, BR_COND, 1'b0);
    resolve(32'd0, 32'h8000_0000, 32'h8000_0100, BR_COND, 1'b1);
    check("dir_redir_valid", bus.redir_valid, 1);
    check("dir_redir_pc", bus.redir_pc, 32'h8000_0100);
    check("dir_redir_ptr", bus.redir_ptr, 0);
    check("dir_cnt_dir", bus.cnt_dir_miss, 1);
    check("dir_cnt_branch", bus.cnt_branch, 1);
    tick();
    check("dir_redir_pulse", bus.redir_valid, 0);

    // Target miss: taken both times, target differs
    push(32'd1, 32'h8000_0010, 32'h0000_9000, BR_JALR, 1'b1);
    resolve(32'd1, 32'h8000_0010, 32'h0000_A000, BR_JALR, 1'b1);
    check("tgt_redir_valid", bus.redir_valid, 1);
    check("tgt_redir_pc", bus.redir_pc, 32'h0000_A000);
    check("tgt_redir_ptr", bus.redir_ptr, 1);
    check("tgt_cnt_tgt", bus.cnt_tgt_miss, 1);
    check("tgt_cnt_dir", bus.cnt_dir_miss, 1);

    // Type miss on a not-taken branch: counted as direction miss, fall-through PC
    push(32'd2, 32'h8000_0020, 32'h0000_0000, BR_COND, 1'b0);
    resolve(32'd2, 32'h8000_0020, 32'h0000_0000, BR_JAL, 1'b0);
    check("type_redir_valid", bus.redir_valid, 1);
    check("type_redir_pc", bus.redir_pc, 32'h8000_0024);
    check("type_cnt_dir", bus.cnt_dir_miss, 2);
    check("type_cnt_tgt", bus.cnt_tgt_miss, 1);
    check("type_cnt_branch", bus.cnt_branch, 3);

    // Fill the queue: ptr 3..18
    for (int i = 3; i < 19; i++)
      push(32'(i), 32'(32'h100 + 4 * i), 32'h0, BR_COND, 1'b0);
    check("full_pred_ready", bus.pred_ready, 0);
    check("full_err", bus.err, 0);

    // Push attempt while full plus a resolve of the head
    set_pred(32'd19, 32'h14C, 32'h0, BR_COND, 1'b0);
    set_res(32'd3, 32'h10C, 32'h0, BR_COND, 1'b0);
    tick();
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    check("full_pop_ready", bus.pred_ready, 1);
    check("full_pop_err", bus.err, 0);
    check("full_pop_cnt_branch", bus.cnt_branch, 4);
    push(32'd19, 32'h14C, 32'h0, BR_COND, 1'b0);
    check("full_refill_ready", bus.pred_ready, 0);
    check("full_refill_err", bus.err, 0);

    // Pointer mismatch on resolve: head is ptr 4
    resolve(32'd5, 32'h114, 32'h0, BR_COND, 1'b0);
    check("ptr_err", bus.err, 1);
    check("ptr_err_code", bus.err_code, 2);
    check("ptr_pred_ready", bus.pred_ready, 0);
    check("ptr_redir_valid", bus.redir_valid, 0);
    push(32'd20, 32'h150, 32'h0, BR_COND, 1'b0);
    resolve(32'd4, 32'h110, 32'h0, BR_COND, 1'b0);
    check("sticky_err_code", bus.err_code, 2);
    check("sticky_cnt_branch", bus.cnt_branch, 4);
    check("sticky_pred_ready", bus.pred_ready, 0);

    // Flush with concurrent resolve
    pulse_reset();
    for (int i = 0; i < 5; i++)
      push(32'(i), 32'(32'h200 + 4 * i), 32'h0, BR_COND, 1'b0);
    bus.flush_valid = 1'b1;
    bus.flush_ptr   = 32'h20;
    set_res(32'd0, 32'h200, 32'h0, BR_COND, 1'b0);
    tick();
    bus.flush_valid = 1'b0;
    bus.res_valid   = 1'b0;
    check("flush_cnt_branch", bus.cnt_branch, 0);
    check("flush_err", bus.err, 0);
    check("flush_pred_ready", bus.pred_ready, 1);
    push(32'h20, 32'h300, 32'h400, BR_JAL, 1'b1);
    check("flush_newptr_err", bus.err, 0);
    resolve(32'h20, 32'h300, 32'h400, BR_JAL, 1'b1);
    check("flush_resolve_cnt", bus.cnt_branch, 1);
    check("flush_resolve_redir", bus.redir_valid, 0);
    check("flush_resolve_err", bus.err, 0);

    // Resolve with the queue empty
    resolve(32'h21, 32'h304, 32'h0, BR_COND, 1'b0);
    check("empty_err", bus.err, 1);
    check("empty_err_code", bus.err_code, 1);
    check("empty_cnt_branch", bus.cnt_branch, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
